// File: rtl/adder_fifo_n.sv
// -----------------------------------------------------------------------------
// adder_fifo_n
//
// Adds or subtracts two unsigned operands and queues the (WIDTH+1)-bit results
// in a first-word fall-through FIFO of DEPTH entries.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   rst        : synchronous reset, active-low
//   enable     : global enable; when low nothing is pushed or popped
//   A, B       : unsigned operands, WIDTH bits
//   mode       : 0 = A+B, 1 = A-B (sampled with the operands)
//   in_valid   : operands valid
//   in_ready   : block accepts operands this cycle (enable & !full)
//   Sum        : result at buffer head, 0 when empty
//   out_valid  : Sum holds a valid result (enable & !empty)
//   out_ready  : consumer takes Sum this cycle
//   count      : number of stored results, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
//   overflow   : sticky, set when operands are offered while full
// -----------------------------------------------------------------------------
module adder_fifo_n #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH:0]           Sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [WIDTH:0]     entry;
  logic               push;
  logic               pop;

  // Both operands are zero-extended before the operation, so the MSB carries
  // the carry for add and the borrow for subtract.
  always_comb begin
    entry = '0;
    if (mode) entry = {1'b0, A} - {1'b0, B};
    else      entry = {1'b0, A} + {1'b0, B};
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = enable & ~full;
  assign out_valid = enable & ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // First-word fall-through: the head is visible combinationally; an empty
  // buffer shows 0 rather than stale storage.
  assign Sum = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; stale words are unreachable because
  // Sum is forced to 0 while empty and the pointers restart at 0.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of push/pop/count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (enable) begin
      // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 by
      // natural binary overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (in_valid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/adder_fifo_n.md
ADDER_FIFO_N -- requirements
Module: adder_fifo_n

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, minimum 1.
REQ-002 Parameter DEPTH, default 4: result buffer entries, power of two, minimum 2.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-low.
REQ-005 Port enable  input  1: global enable; when low, no push, no pop, state held.
REQ-006 Port A  input  WIDTH: operand A, unsigned.
REQ-007 Port B  input  WIDTH: operand B, unsigned.
REQ-008 Port mode  input  1: 0 = A+B, 1 = A-B; sampled with the operands.
REQ-009 Port in_valid  input  1: operands valid.
REQ-010 Port in_ready  output  1: block accepts operands this cycle.
REQ-011 Port Sum  output  WIDTH+1: result at buffer head.
REQ-012 Port out_valid  output  1: Sum holds a valid result.
REQ-013 Port out_ready  input  1: consumer takes Sum this cycle.
REQ-014 Port count  output  $clog2(DEPTH)+1: number of stored results, 0..DEPTH.
REQ-015 Port full  output  1: count == DEPTH.
REQ-016 Port empty  output  1: count == 0.
REQ-017 Port overflow  output  1: sticky flag for an operand offered while full.

Function
REQ-018 in_ready SHALL equal enable & !full, combinationally.
REQ-019 Push SHALL occur on a rising edge when in_valid & in_ready.
REQ-020 The pushed entry SHALL be computed from A, B and mode sampled at the push edge.
REQ-021 mode=0: entry = zero-extended A + zero-extended B, (WIDTH+1) bits, carry in MSB.
REQ-022 mode=1: entry = (A - B) mod 2^(WIDTH+1); MSB set means borrow (A < B).
REQ-023 out_valid SHALL equal enable & !empty, combinationally.
REQ-024 Sum SHALL show the oldest entry whenever empty=0 (first-word fall-through), and 0 when empty=1.
REQ-025 Pop SHALL occur on a rising edge when out_valid & out_ready.
REQ-026 Latency: a result pushed at edge N SHALL appear at Sum with out_valid=1 in the cycle after edge N, if it is at the head.
REQ-027 Ordering SHALL be strict FIFO; no entry is lost or duplicated.
REQ-028 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-029 Push and pop in the same edge SHALL leave count unchanged and advance both pointers.
REQ-030 When empty, a push SHALL NOT pop in the same edge, because out_valid=0.
REQ-031 When full, in_ready=0, so no push occurs; a pop in that edge takes count to DEPTH-1.
REQ-032 overflow SHALL set on an edge with enable & in_valid & full, and SHALL stay set until reset.
REQ-033 With enable=0: pointers, count, contents and overflow SHALL hold, and in_valid/out_ready are ignored.

Reset
REQ-034 When rst=0 at a rising edge, the following SHALL apply:
- pointers and count = 0
- empty = 1, full = 0, overflow = 0
- out_valid = 0, Sum = 0
REQ-035 Reset SHALL dominate enable and all handshakes.
REQ-036 Reset mid-operation SHALL discard all stored entries; the first push after release is at the head.
REQ-037 in_ready SHALL be 1 in the first cycle after release when enable=1.

Verification (WIDTH=4, DEPTH=4)
REQ-038 Add with carry: push A=15, B=1, mode=0, out_ready=0 -> next cycle out_valid=1, Sum=5'b10000, count=1.
REQ-039 Subtract with borrow: push A=3, B=5, mode=1 -> Sum=5'b11110; then A=9, B=4, mode=1 -> Sum=5'b00101.
REQ-040 Fill and overflow:
- push 1+1, 2+2, 3+3, 4+4 with out_ready=0 -> full=1, count=4, in_ready=0
- then in_valid=1 one cycle -> overflow=1, count stays 4
- then drain -> Sum sequence 2, 4, 6, 8, then empty=1
REQ-041 Simultaneous push/pop at count=2 for 6 cycles -> count stays 2, pointers wrap, outputs stay in order.
REQ-042 Enable stall: at count=2 drive enable=0 with in_valid=1 and out_ready=1 for 3 cycles -> in_ready=0, out_valid=0, count=2; on enable=1, Sum is the original head.
REQ-043 Reset mid-run: at count=3 with overflow=1 drive rst=0 for one edge -> count=0, empty=1, overflow=0, Sum=0; next push 7+7 -> Sum=14.
